// File: rtl/lsq_mem_port.sv
// LSQ-to-data-memory port: pops the oldest LSQ entry, runs one req/gnt/rvalid
// transaction at a time and returns load results. Optional: LSQ_MEM_ALIGN_CHECK_EN.
module lsq_mem_port #(
  parameter int PC_WIDTH       = 12,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  lsq_valid,
  input  logic                  lsq_is_load,
  input  logic [PC_WIDTH-1:0]   lsq_pc,
  input  logic [ADDR_WIDTH-1:0] lsq_addr,
  input  logic [DATA_WIDTH-1:0] lsq_data,
  output logic                  lsq_pop,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [PC_WIDTH-1:0]   wb_pc,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_err,
  input  logic                  wb_ready,
  output logic                  st_done,
`ifdef LSQ_MEM_ALIGN_CHECK_EN
  output logic                  err_misalign,
`endif
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t                state, state_nxt;
  logic                  kill, kill_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  st_done_r, st_done_nxt;
  logic                  wb_err_r, wb_err_nxt;
  logic                  pop;
  logic                  rdata_load, rdata_zero;

  logic                  is_load_p1;
  logic [PC_WIDTH-1:0]   pc_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [DATA_WIDTH-1:0] rdata_p2;

`ifdef LSQ_MEM_ALIGN_CHECK_EN
  logic                  misalign_r, misalign_nxt;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt   = state;
    kill_nxt    = kill;
    cnt_nxt     = cnt;
    st_done_nxt = 1'b0;
    wb_err_nxt  = wb_err_r;
    pop         = 1'b0;
    rdata_load  = 1'b0;
    rdata_zero  = 1'b0;
`ifdef LSQ_MEM_ALIGN_CHECK_EN
    misalign_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        kill_nxt = 1'b0;
        pop      = lsq_valid & ~flush;
        if (pop) begin
`ifdef LSQ_MEM_ALIGN_CHECK_EN
          // Misaligned entries are resolved locally and never reach memory
          if (lsq_addr[1:0] != 2'b00) begin
            if (lsq_is_load) begin
              state_nxt  = WB;
              wb_err_nxt = 1'b1;
              rdata_zero = 1'b1;
            end else begin
              st_done_nxt  = 1'b1;
              misalign_nxt = 1'b1;
            end
          end else begin
            state_nxt = REQ;
          end
`else
          state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        // The handshake cannot be aborted; a flush only marks the op as killed
        kill_nxt = kill | flush;
        if (mem_gnt) begin
          if (is_load_p1) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end else begin
            state_nxt   = IDLE;
            st_done_nxt = ~(kill | flush);
          end
        end
      end
      WAIT: begin
        kill_nxt = kill | flush;
        cnt_nxt  = sat_inc(cnt);
        if (mem_rvalid || (cnt >= CNT_LAST)) begin
          state_nxt  = (kill | flush) ? IDLE : WB;
          wb_err_nxt = ~mem_rvalid;
          rdata_load = mem_rvalid;
          rdata_zero = ~mem_rvalid;
        end
      end
      WB: begin
        if (wb_ready || flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      kill      <= 1'b0;
      cnt       <= '0;
      st_done_r <= 1'b0;
      wb_err_r  <= 1'b0;
`ifdef LSQ_MEM_ALIGN_CHECK_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      kill      <= kill_nxt;
      cnt       <= cnt_nxt;
      st_done_r <= st_done_nxt;
      wb_err_r  <= wb_err_nxt;
`ifdef LSQ_MEM_ALIGN_CHECK_EN
      misalign_r <= misalign_nxt;
`endif
    end
  end

  // Entry latch (p1) and response capture (p2)
  always_ff @(posedge clk) begin
    if (pop) begin
      is_load_p1 <= lsq_is_load;
      pc_p1      <= lsq_pc;
      addr_p1    <= lsq_addr;
      data_p1    <= lsq_data;
    end
    if (rdata_load) begin
      rdata_p2 <= mem_rdata;
    end else if (rdata_zero) begin
      rdata_p2 <= '0;
    end
  end

  // Data outputs are gated by state so they read 0 whenever idle or in reset
  assign lsq_pop   = pop & rst;
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & ~is_load_p1;
  assign mem_addr  = mem_req ? addr_p1 : '0;
  assign mem_wdata = mem_we ? data_p1 : '0;
  assign wb_valid  = (state == WB);
  assign wb_pc     = wb_valid ? pc_p1 : '0;
  assign wb_data   = wb_valid ? rdata_p2 : '0;
  assign wb_err    = wb_valid & wb_err_r;
  assign st_done   = st_done_r;
  assign busy      = (state != IDLE);
`ifdef LSQ_MEM_ALIGN_CHECK_EN
  assign err_misalign = misalign_r;
`endif

endmodule

// File: tb/tb_lsq_mem_port.sv
// Directed + randomized bench for lsq_mem_port with a transaction-level model.
module tb_lsq_mem_port;

  localparam int PCW = 12;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int T   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush, lsq_valid, lsq_is_load;
  logic [PCW-1:0] lsq_pc;
  logic [AW-1:0]  lsq_addr;
  logic [DW-1:0]  lsq_data;
  logic           lsq_pop, mem_req, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_gnt, mem_rvalid;
  logic [DW-1:0]  mem_rdata;
  logic           wb_valid;
  logic [PCW-1:0] wb_pc;
  logic [DW-1:0]  wb_data;
  logic           wb_err, wb_ready, st_done, busy;
`ifdef LSQ_MEM_ALIGN_CHECK_EN
  logic           err_misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsq_mem_port #(.PC_WIDTH(PCW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsq_valid(lsq_valid), .lsq_is_load(lsq_is_load), .lsq_pc(lsq_pc),
    .lsq_addr(lsq_addr), .lsq_data(lsq_data), .lsq_pop(lsq_pop),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_data(wb_data), .wb_err(wb_err),
    .wb_ready(wb_ready), .st_done(st_done),
`ifdef LSQ_MEM_ALIGN_CHECK_EN
    .err_misalign(err_misalign),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    flush = 1'b0; lsq_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_wbv"}, wb_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_store(input logic [PCW-1:0] pc, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int gnt_dly, input bit kill);
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b0; lsq_pc = pc; lsq_addr = addr; lsq_data = data;
    settle();
    chk("st_pop", lsq_pop, 1'b1);
    for (int i = 0; i <= gnt_dly; i++) begin
      tick();
      lsq_valid = 1'b1; lsq_is_load = $urandom_range(0, 1); lsq_addr = $urandom; lsq_data = $urandom;
      mem_gnt = (i == gnt_dly);
      flush = kill && (i == 0);
      settle();
      chk("st_req", mem_req, 1'b1);
      chk("st_we", mem_we, 1'b1);
      chk("st_addr", mem_addr, addr);
      chk("st_wdata", mem_wdata, data);
      chk("st_nopop", lsq_pop, 1'b0);
    end
    tick();
    settle();
    chk("st_done", st_done, !kill);
    check_quiet("st_end");
    tick();
    settle();
    chk("st_done_pulse", st_done, 1'b0);
    chk("st_wbv", wb_valid, 1'b0);
  endtask

  task automatic do_load(input logic [PCW-1:0] pc, input logic [AW-1:0] addr, input int gnt_dly,
                         input int rv_dly, input logic [DW-1:0] rdata, input int rdy_dly,
                         input bit early_rv);
    int            exp_wait;
    bit            exp_err;
    logic [DW-1:0] exp_data;
    exp_err  = (rv_dly >= T);
    exp_wait = exp_err ? T : rv_dly + 1;
    exp_data = exp_err ? '0 : rdata;
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_pc = pc; lsq_addr = addr; lsq_data = $urandom;
    settle();
    chk("ld_pop", lsq_pop, 1'b1);
    for (int i = 0; i <= gnt_dly; i++) begin
      tick();
      mem_gnt = (i == gnt_dly);
      if (early_rv && i == gnt_dly) begin
        mem_rvalid = 1'b1; mem_rdata = ~rdata;
      end
      settle();
      chk("ld_req", mem_req, 1'b1);
      chk("ld_we", mem_we, 1'b0);
      chk("ld_addr", mem_addr, addr);
    end
    for (int w = 0; w < exp_wait; w++) begin
      tick();
      mem_rvalid = (w == rv_dly);
      mem_rdata  = (w == rv_dly) ? rdata : DW'($urandom);
      settle();
      chk("ld_wait_busy", busy, 1'b1);
      chk("ld_wait_req", mem_req, 1'b0);
      chk("ld_wait_wbv", wb_valid, 1'b0);
    end
    for (int r = 0; r <= rdy_dly; r++) begin
      tick();
      wb_ready = (r == rdy_dly);
      settle();
      chk("ld_wbv", wb_valid, 1'b1);
      chk("ld_wbpc", wb_pc, pc);
      chk("ld_wbdata", wb_data, exp_data);
      chk("ld_wberr", wb_err, exp_err);
      chk("ld_stdone", st_done, 1'b0);
    end
    tick();
    settle();
    check_quiet("ld_end");
  endtask

  initial begin
    flush = 0; lsq_valid = 0; lsq_is_load = 0; lsq_pc = 0; lsq_addr = 0; lsq_data = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    lsq_valid = 1'b1;
    #2;
    chk("rst_pop", lsq_pop, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_err", wb_err, 1'b0);
    chk("rst_stdone", st_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    tick();
    tick();
    rst = 1'b1;

    do_store(12'h010, 32'h100, 32'hDEADBEEF, 1, 1'b0);
    do_load(12'h04C, 32'h200, 0, 2, 32'h12345678, 2, 1'b0);
    do_load(12'h050, 32'h204, 0, T, 32'hAAAA5555, 0, 1'b0);
    do_load(12'h054, 32'h208, 1, T - 1, 32'h0BADF00D, 1, 1'b0);
    do_load(12'h058, 32'h20C, 0, 0, 32'hCAFEBABE, 0, 1'b1);

    // flush in IDLE suppresses the pop
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_addr = 32'h300; flush = 1'b1;
    settle();
    chk("fl_idle_pop", lsq_pop, 1'b0);
    tick();
    settle();
    check_quiet("fl_idle");

    // flush during WAIT, queued store pops right after the killed response
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_pc = 12'h060; lsq_addr = 32'h310;
    settle();
    chk("fw_pop", lsq_pop, 1'b1);
    tick();
    mem_gnt = 1'b1;
    settle();
    chk("fw_req", mem_req, 1'b1);
    tick();
    flush = 1'b1; lsq_valid = 1'b1; lsq_is_load = 1'b0; lsq_pc = 12'h064;
    lsq_addr = 32'h400; lsq_data = 32'h13572468;
    settle();
    chk("fw_nopop0", lsq_pop, 1'b0);
    tick();
    lsq_valid = 1'b1;
    settle();
    chk("fw_nopop1", lsq_pop, 1'b0);
    tick();
    lsq_valid = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    settle();
    chk("fw_wbv0", wb_valid, 1'b0);
    tick();
    lsq_valid = 1'b1;
    settle();
    chk("fw_wbv1", wb_valid, 1'b0);
    chk("fw_repop", lsq_pop, 1'b1);
    tick();
    mem_gnt = 1'b1;
    settle();
    chk("fw_st_addr", mem_addr, 32'h400);
    chk("fw_st_we", mem_we, 1'b1);
    tick();
    settle();
    chk("fw_st_done", st_done, 1'b1);
    tick();
    settle();
    check_quiet("fw_end");

    // flush in REQ: killed store and killed load
    do_store(12'h070, 32'h500, 32'h55AA55AA, 2, 1'b1);
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_pc = 12'h074; lsq_addr = 32'h504;
    settle();
    tick();
    flush = 1'b1;
    settle();
    chk("fr_req", mem_req, 1'b1);
    tick();
    mem_gnt = 1'b1;
    settle();
    chk("fr_req_hold", mem_req, 1'b1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    settle();
    chk("fr_wait", busy, 1'b1);
    tick();
    settle();
    check_quiet("fr_end");

    // flush in WB drops the result
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_pc = 12'h080; lsq_addr = 32'h600;
    settle();
    tick();
    mem_gnt = 1'b1;
    settle();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h31415926;
    settle();
    tick();
    flush = 1'b1;
    settle();
    chk("fb_wbv", wb_valid, 1'b1);
    chk("fb_data", wb_data, 32'h31415926);
    tick();
    settle();
    check_quiet("fb_end");

    // reset mid-WAIT, stale rvalid after release is ignored
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_pc = 12'h090; lsq_addr = 32'h700;
    settle();
    tick();
    mem_gnt = 1'b1;
    settle();
    tick();
    settle();
    chk("rw_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rw_busy0", busy, 1'b0);
    chk("rw_wbv", wb_valid, 1'b0);
    chk("rw_req", mem_req, 1'b0);
    chk("rw_wbdata", wb_data, 32'h0);
    tick();
    rst = 1'b1;
    settle();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h42424242;
    settle();
    check_quiet("rw_stale0");
    tick();
    settle();
    check_quiet("rw_stale1");

    // randomized operations
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_store(PCW'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 2), 1'b0);
      else
        do_load(PCW'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2),
                $urandom_range(0, T + 1), $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

`ifdef LSQ_MEM_ALIGN_CHECK_EN
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b1; lsq_pc = 12'h055; lsq_addr = 32'h203;
    settle();
    chk("ma_pop", lsq_pop, 1'b1);
    tick();
    settle();
    chk("ma_req", mem_req, 1'b0);
    chk("ma_wbv", wb_valid, 1'b1);
    chk("ma_err", wb_err, 1'b1);
    chk("ma_data", wb_data, 32'h0);
    tick();
    wb_ready = 1'b1;
    settle();
    chk("ma_req1", mem_req, 1'b0);
    tick();
    settle();
    check_quiet("ma_end");
    tick();
    lsq_valid = 1'b1; lsq_is_load = 1'b0; lsq_addr = 32'h102; lsq_data = 32'h1;
    settle();
    tick();
    settle();
    chk("ms_stdone", st_done, 1'b1);
    chk("ms_err", err_misalign, 1'b1);
    check_quiet("ms");
    tick();
    settle();
    chk("ms_stdone0", st_done, 1'b0);
    chk("ms_err0", err_misalign, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsq_mem_port.md
Name: lsq_mem_port

Overview:
- Downstream consumer of the load/store queue.
- Pops the oldest LSQ entry, issues it to the data memory over a req/gnt/rvalid handshake, and returns load results to writeback.
- Processes one memory operation at a time, in program order.
- Provides a response timeout and a flush path for pipeline squash.

Parameters:
- PC_WIDTH, 12, width of the instruction PC carried with each entry
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, load/store data width
- TIMEOUT_CYCLES, 64, maximum number of cycles in WAIT before an error response is forced

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of the in-flight operation
- lsq_valid  in  1  LSQ head entry is valid
- lsq_is_load  in  1  1 = load, 0 = store
- lsq_pc  in  PC_WIDTH  PC of the head entry
- lsq_addr  in  ADDR_WIDTH  effective address
- lsq_data  in  DATA_WIDTH  store data; ignored for loads
- lsq_pop  out  1  head entry consumed this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  request address
- mem_wdata  out  DATA_WIDTH  write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- wb_valid  out  1  load result available
- wb_pc  out  PC_WIDTH  PC of the completed load
- wb_data  out  DATA_WIDTH  load result
- wb_err  out  1  result is an error: timeout, or misaligned when the optional feature is built in
- wb_ready  in  1  writeback accepts the result
- st_done  out  1  single-cycle pulse: store granted by memory
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; the timeout counter and the kill flag clear.
  - All outputs read 0, including lsq_pop, mem_req, wb_valid, wb_err and st_done.
  - Reset mid-transaction abandons the operation. No response is emitted after reset deasserts; a stale mem_rvalid is ignored because the state is IDLE.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - lsq_pop = lsq_valid & !flush, combinational.
  - On a pop: latch is_load, pc, addr and data, then go to REQ next cycle.
  - Latency is one cycle from pop to the first mem_req.
- REQ:
  - mem_req = 1; mem_we = !is_load; mem_addr and mem_wdata come from the latched values.
  - All four stay stable until mem_gnt.
  - Store with mem_gnt: st_done pulses on the next cycle, then IDLE.
  - Load with mem_gnt: go to WAIT and clear the counter.
  - mem_rvalid in the same cycle as mem_gnt is not accepted; a response is accepted only in WAIT.
- WAIT:
  - The counter increments each cycle.
  - On mem_rvalid: capture mem_rdata and go to WB with wb_err = 0.
  - If the counter reaches TIMEOUT_CYCLES-1 with no rvalid: go to WB with wb_data = 0 and wb_err = 1.
  - If rvalid and timeout occur in the same cycle, rvalid wins.
- WB:
  - wb_valid = 1; wb_pc, wb_data and wb_err are held stable until wb_ready.
  - On the wb_ready cycle: go to IDLE. No new pop happens in that same cycle; the next pop occurs one cycle later.
- flush:
  - In IDLE: suppresses the pop.
  - In WB: drops the result and goes to IDLE.
  - In REQ: the request must complete because the handshake is non-abortable. Set the kill flag, finish the grant, and for a load consume the response in WAIT. A killed operation returns to IDLE without wb_valid or st_done.
  - In WAIT: set the kill flag; the operation then follows the same killed path as above.
- Width rule: the counter is $clog2(TIMEOUT_CYCLES)+1 bits and saturates; it never wraps.
- A store never produces wb_valid. A load never produces st_done.

Optional Feature:
- Macro: LSQ_MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a popped entry with lsq_addr[1:0] != 0 never reaches REQ and never asserts mem_req.
  - A misaligned load goes directly to WB with wb_err = 1 and wb_data = 0.
  - A misaligned store returns to IDLE with st_done pulsed and an err_misalign output pulsed on the same cycle. The err_misalign port exists only when the macro is defined.
- Undefined: addresses are passed to memory unmodified, and no alignment logic is present.

Test Plan:
- Store at 0x100, data 0xDEADBEEF, mem_gnt on the 2nd REQ cycle -> mem_we = 1, mem_addr = 0x100 held for 2 cycles, st_done pulses once, no wb_valid.
- Load at 0x200, pc 0x04C; gnt immediate; rvalid after 3 cycles with 0x12345678; wb_ready low for 2 cycles -> wb_valid held, wb_data = 0x12345678, wb_pc = 0x04C, then busy = 0.
- Load with no rvalid, TIMEOUT_CYCLES = 8 -> wb_valid appears after 8 WAIT cycles with wb_err = 1, wb_data = 0.
- flush asserted during WAIT of a load, rvalid 2 cycles later -> no wb_valid; returns to IDLE; the next queued entry pops on the following cycle.
- rst driven low mid-WAIT, then mem_rvalid pulsed after release -> all outputs 0, state IDLE, the rvalid is ignored.
- With LSQ_MEM_ALIGN_CHECK_EN, load at 0x203 -> mem_req never asserts; wb_valid with wb_err = 1 one cycle after the pop.
